// File: rtl/fifo_rd_fwft_if.sv
// Read-side FWFT stage bus.
// The stage drives the master modport. The pointer/empty logic and the
// consumer sit on the slave modport.
interface fifo_rd_fwft_if #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic [DSIZE-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [1:0]       rd_level;
    logic [CNTW-1:0]  rd_words;

    modport master (
        input  rempty, rdata, dout_ready,
        output rinc, dout, dout_valid, rd_level, rd_words
    );

    modport slave (
        output rempty, rdata, dout_ready,
        input  rinc, dout, dout_valid, rd_level, rd_words
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through output stage for the async FIFO read side.
// Holds up to two words (head + skid) so that a registered fetch decision
// never depends on dout_ready, yet back-pressure loses nothing.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | no word buffered, dout_valid=0
// S_ONE   | head holds the next word
// S_TWO   | head and skid both hold words; fetching stalls
module fifo_rd_fwft #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic          rclk,
    input  logic          rrst_n,
    fifo_rd_fwft_if.master bus
);

    // Encoding equals buffer occupancy so rd_level is the state register.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic [CNTW-1:0]  words_q, words_d;
    logic             fetch;
    logic             pop;

    // Fetch sees only registered state and the registered empty flag.
    assign fetch = ~bus.rempty & (state_q != S_TWO);
    assign pop   = (state_q != S_EMPTY) & bus.dout_ready;

    // Next-state and buffer updates.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        words_d = words_q;
        case (state_q)
            S_EMPTY: begin
                if (fetch) begin
                    state_d = S_ONE;
                    head_d  = bus.rdata;
                end
            end
            S_ONE: begin
                if (fetch && !pop) begin
                    state_d = S_TWO;
                    skid_d  = bus.rdata;
                end else if (fetch && pop) begin
                    head_d  = bus.rdata;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (pop && (words_q != {CNTW{1'b1}})) begin
            words_d = words_q + 1'b1;
        end
    end

    // State and data registers; reset discards any buffered words.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            words_q <= words_d;
        end
    end

    assign bus.rinc       = fetch;
    assign bus.dout       = head_q;
    assign bus.dout_valid = (state_q != S_EMPTY);
    assign bus.rd_level   = state_q;
    assign bus.rd_words   = words_q;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: a FIFO source model feeds rempty/rdata, a
// scoreboard queue holds words in load order and a monitor pops and
// compares on every accepted word.
module tb_fifo_rd_fwft;

    logic rclk;
    logic rrst_n;

    fifo_rd_fwft_if #(.DSIZE(8), .CNTW(16)) bus ();
    fifo_rd_fwft_if #(.DSIZE(8), .CNTW(2))  bus2 ();

    fifo_rd_fwft #(.DSIZE(8), .CNTW(16)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    fifo_rd_fwft #(.DSIZE(8), .CNTW(2)) dut_sat (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus2)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic       rinc_s = 1'b0;
    int         rinc_cnt = 0;
    int         pop_cnt  = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_val  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void drive_src();
        bus.rempty = (src_q.size() == 0);
        bus.rdata  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endfunction

    function automatic void load(input logic [7:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        drive_src();
    endfunction

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    // Source model: a word is consumed at the edge following a sampled rinc.
    always @(negedge rclk) begin
        rinc_s = bus.rinc;
        if (bus.rinc) rinc_cnt++;
    end

    always @(posedge rclk) begin
        #1;
        if (rinc_s && src_q.size() != 0) void'(src_q.pop_front());
        drive_src();
    end

    // Monitor: compares each accepted word and watches hold/level rules.
    always @(negedge rclk) begin
        if (!rrst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (bus.rinc && bus.rempty) check("rinc_while_empty", 32'(bus.rinc), 32'd0);
            if (bus.rd_level > 2'd2) check("level_range", 32'(bus.rd_level), 32'd2);
            if (hold_pend && bus.dout_valid) check("dout_hold", 32'(bus.dout), 32'(hold_val));
            if (bus.dout_valid && bus.dout_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(bus.dout), 32'hFFFF_FFFF);
                end else begin
                    check("dout_word", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
            end
            hold_pend = bus.dout_valid && !bus.dout_ready;
            hold_val  = bus.dout;
        end
    end

    initial begin
        rrst_n          = 1'b0;
        bus.rempty      = 1'b1;
        bus.rdata       = 8'h00;
        bus.dout_ready  = 1'b0;
        bus2.rempty     = 1'b1;
        bus2.rdata      = 8'h77;
        bus2.dout_ready = 1'b1;

        // Reset with rempty=1.
        #3;
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_level", 32'(bus.rd_level), 32'd0);
        check("rst_rinc", 32'(bus.rinc), 32'd0);
        check("rst_words", 32'(bus.rd_words), 32'd0);
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(bus.dout_valid), 32'd0);
        check("post_rst_level", 32'(bus.rd_level), 32'd0);
        check("post_rst_rinc", 32'(bus.rinc), 32'd0);
        check("post_rst_words", 32'(bus.rd_words), 32'd0);

        // Saturating counter with CNTW=2: five pops.
        check("sat_rst_words", 32'(bus2.rd_words), 32'd0);
        bus2.rempty = 1'b0;
        repeat (3) tick();
        check("sat_words_2", 32'(bus2.rd_words), 32'd2);
        repeat (2) tick();
        bus2.rempty = 1'b1;
        repeat (3) tick();
        check("sat_words_3", 32'(bus2.rd_words), 32'd3);
        check("sat_valid", 32'(bus2.dout_valid), 32'd0);

        // Streaming three words.
        rinc_cnt = 0;
        pop_cnt  = 0;
        bus.dout_ready = 1'b1;
        load(8'h11);
        load(8'h22);
        load(8'h33);
        repeat (4) tick();
        check("stream_pops", 32'(pop_cnt), 32'd3);
        repeat (4) tick();
        check("stream_rinc_cycles", 32'(rinc_cnt), 32'd3);
        check("stream_words", 32'(bus.rd_words), 32'd3);
        check("stream_empty", 32'(bus.dout_valid), 32'd0);

        // Back-pressure fills head and skid, then drains without gaps.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        repeat (3) tick();
        check("bp_level", 32'(bus.rd_level), 32'd2);
        check("bp_dout", 32'(bus.dout), 32'hA0);
        check("bp_rinc", 32'(bus.rinc), 32'd0);
        repeat (2) tick();
        check("bp_dout_later", 32'(bus.dout), 32'hA0);
        pop_cnt = 0;
        bus.dout_ready = 1'b1;
        repeat (5) tick();
        check("drain_pops", 32'(pop_cnt), 32'd5);
        tick();
        check("drain_valid", 32'(bus.dout_valid), 32'd0);
        check("drain_words", 32'(bus.rd_words), 32'd8);

        // Toggling ready over eight words.
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) load(8'hB0 + 8'(i));
        for (int i = 0; i < 30; i++) begin
            bus.dout_ready = ~bus.dout_ready;
            tick();
        end
        bus.dout_ready = 1'b1;
        repeat (4) tick();
        check("toggle_pops", 32'(pop_cnt), 32'd8);
        check("toggle_left", 32'(exp_q.size()), 32'd0);
        check("toggle_words", 32'(bus.rd_words), 32'd16);

        // Reset mid-stream at level 2.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
        repeat (3) tick();
        check("pre_rst_level", 32'(bus.rd_level), 32'd2);
        #1 rrst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
        check("mid_rst_level", 32'(bus.rd_level), 32'd0);
        check("mid_rst_dout", 32'(bus.dout), 32'd0);
        check("mid_rst_words", 32'(bus.rd_words), 32'd0);
        src_q.delete();
        exp_q.delete();
        drive_src();
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
        #1;
        load(8'h5A);
        tick();
        check("after_rst_dout", 32'(bus.dout), 32'h5A);
        check("after_rst_valid", 32'(bus.dout_valid), 32'd1);
        bus.dout_ready = 1'b1;
        repeat (2) tick();
        check("after_rst_left", 32'(exp_q.size()), 32'd0);
        check("after_rst_words", 32'(bus.rd_words), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
